button_conditioner: RTL and testbench

- Input-side counterpart to the board's 7-segment output path.
- Takes raw mechanical push-button levels from the Basys 3 and synchronizes them to clk, then debounces them.
- Emits clean levels plus single-cycle press, release and auto-repeat pulses for the counter/display logic in the top level.
- Each button is handled by an identical, independent channel.

---
 rtl/button_conditioner_pkg.sv | 27 ++
 rtl/button_conditioner_if.sv | 31 +++
 rtl/button_conditioner_channel.sv | 144 ++++++++++++++
 rtl/button_conditioner.sv | 44 ++++
 tb/tb_button_conditioner.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared types and helpers for the push-button conditioner: channel FSM
// state encoding and the counter width derived from the timing parameters.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_DEB   = 3'd1,
    PRESSED     = 3'd2,
    REPEAT      = 3'd3,
    RELEASE_DEB = 3'd4
  } btn_state_t;

  // One counter serves debounce, hold and repeat timing, so it must hold
  // the largest terminal value of the three.
  function automatic int cnt_width(input int deb_cycles, input int hold_cycles,
                                   input int rep_cycles);
    int max_cycles;
    int width;
    max_cycles = deb_cycles;
    if (hold_cycles > max_cycles) max_cycles = hold_cycles;
    if (rep_cycles > max_cycles) max_cycles = rep_cycles;
    width = $clog2(max_cycles);
    if (width < 1) width = 1;
    return width;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the board pins and the counter/display logic:
// raw levels in, debounced level and event pulses out.
interface button_conditioner_if #(
  parameter int N_BUTTONS = 2
);

  logic [N_BUTTONS-1:0] btn_raw;
  logic [N_BUTTONS-1:0] btn_level;
  logic [N_BUTTONS-1:0] btn_press;
  logic [N_BUTTONS-1:0] btn_release;
  logic [N_BUTTONS-1:0] btn_repeat;

  // Board / consumer side: supplies raw levels, observes conditioned outputs.
  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat
  );

endinterface

// File: rtl/button_conditioner_channel.sv
// One button channel: two-flop synchronizer, debounce/hold/repeat FSM with a
// shared timing counter, and registered level/pulse outputs.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic            r_meta;
  logic            r_sync;
  btn_state_t      r_state;
  btn_state_t      w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            r_level;
  logic            w_level_next;
  logic            r_press;
  logic            w_press_next;
  logic            r_release;
  logic            w_release_next;
  logic            r_repeat;
  logic            w_repeat_next;

  // Bring the asynchronous pin level into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // State, timing counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_level   <= w_level_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_repeat  <= w_repeat_next;
    end
  end

  // Next-state logic; a change of the synchronized level always takes
  // priority over a timer expiry in the same cycle.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 1'b1;
    w_level_next   = r_level;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_repeat_next  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (r_sync) w_state_next = PRESS_DEB;
      end
      PRESS_DEB: begin
        if (!r_sync) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = PRESSED;
          w_cnt_next   = '0;
          w_level_next = 1'b1;
          w_press_next = 1'b1;
        end
      end
      PRESSED: begin
        if (!r_sync) begin
          w_state_next = RELEASE_DEB;
          w_cnt_next   = '0;
        end else if (r_cnt == HOLD_LAST) begin
          if (REPEAT_EN) begin
            w_state_next  = REPEAT;
            w_cnt_next    = '0;
            w_repeat_next = 1'b1;
          end else begin
            // Without auto-repeat the hold timer parks at its terminal value.
            w_cnt_next = r_cnt;
          end
        end
      end
      REPEAT: begin
        if (!r_sync) begin
          w_state_next = RELEASE_DEB;
          w_cnt_next   = '0;
        end else if (r_cnt == REP_LAST) begin
          w_cnt_next    = '0;
          w_repeat_next = 1'b1;
        end
      end
      RELEASE_DEB: begin
        if (r_sync) begin
          // Bounce during release: stay pressed and restart hold timing.
          w_state_next = PRESSED;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next   = IDLE;
          w_cnt_next     = '0;
          w_level_next   = 1'b0;
          w_release_next = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
         w_level_next = 1'b0;
      end
    endcase
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: N identical, independent channels turning raw
// Basys 3 button levels into clean levels and press/release/repeat pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  button_conditioner_if.slave  bus
);

  logic [N_BUTTONS-1:0] w_level;
  logic [N_BUTTONS-1:0] w_press;
  logic [N_BUTTONS-1:0] w_release;
  logic [N_BUTTONS-1:0] w_repeat;

  for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_channel (
      .clk       (clk),
      .rst       (rst),
      .i_raw     (bus.btn_raw[gi]),
      .o_level   (w_level[gi]),
      .o_press   (w_press[gi]),
      .o_release (w_release[gi]),
      .o_repeat  (w_repeat[gi])
    );
  end

  assign bus.btn_level   = w_level;
  assign bus.btn_press   = w_press;
  assign bus.btn_release = w_release;
  assign bus.btn_repeat  = w_repeat;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: two DUTs (auto-repeat on / off)
// with DEBOUNCE=4, HOLD=8, REPEAT=3. Stimulus pushes hand-computed pulse
// events; a negedge monitor pops them and compares every cycle.
module tb_button_conditioner;

  localparam int N = 2;

  typedef enum int {K_PRESS, K_RELEASE, K_REPEAT} kind_t;
  typedef struct {
    int    cyc_at;
    int    dut;
    int    ch;
    kind_t kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  bit   done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  ev_t  exp_q [$];
  ev_t  mon_ev;
  logic [N-1:0] exp_level [2] = '{default: '0};
  logic [N-1:0] exp_press [2];
  logic [N-1:0] exp_rel   [2];
  logic [N-1:0] exp_rep   [2];

  button_conditioner_if #(.N_BUTTONS(N)) bus0 ();
  button_conditioner_if #(.N_BUTTONS(N)) bus1 ();

  button_conditioner #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8),
    .REPEAT_CYCLES(3), .REPEAT_EN(1'b1)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  button_conditioner #(
    .N_BUTTONS(N), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(8),
    .REPEAT_CYCLES(3), .REPEAT_EN(1'b0)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic go_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int at, input int d, input int ch, input kind_t k);
    ev_t e;
    e.cyc_at = at;
    e.dut    = d;
    e.ch     = ch;
    e.kind   = k;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, act, req);
    end
  endtask

  // Monitor: pop all events due this cycle and compare every output.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_press[d] = '0;
      exp_rel[d]   = '0;
      exp_rep[d]   = '0;
    end
    while (exp_q.size() != 0 && exp_q[0].cyc_at == cyc) begin
      mon_ev = exp_q.pop_front();
      case (mon_ev.kind)
        K_PRESS: begin
          exp_press[mon_ev.dut][mon_ev.ch] = 1'b1;
          exp_level[mon_ev.dut][mon_ev.ch] = 1'b1;
        end
        K_RELEASE: begin
          exp_rel[mon_ev.dut][mon_ev.ch]   = 1'b1;
          exp_level[mon_ev.dut][mon_ev.ch] = 1'b0;
        end
        default: exp_rep[mon_ev.dut][mon_ev.ch] = 1'b1;
      endcase
    end
    if (!rst) begin
      exp_level[0] = '0;
      exp_level[1] = '0;
    end
    check("level_d0",   bus0.btn_level,   exp_level[0]);
    check("press_d0",   bus0.btn_press,   exp_press[0]);
    check("release_d0", bus0.btn_release, exp_rel[0]);
    check("repeat_d0",  bus0.btn_repeat,  exp_rep[0]);
    check("level_d1",   bus1.btn_level,   exp_level[1]);
    check("press_d1",   bus1.btn_press,   exp_press[1]);
    check("release_d1", bus1.btn_release, exp_rel[1]);
    check("repeat_d1",  bus1.btn_repeat,  exp_rep[1]);
    if (done) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL queue_drained actual=%0d pending required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // Stimulus: a raw change applied just after edge b is first sampled at
  // edge b+1, so press/release pulses are due at b+7.
  initial begin
    int b;
    bus0.btn_raw = '0;
    bus1.btn_raw = '0;
    go_to(3);
    rst = 1'b1;
    go_to(5);

    // 1: clean press / release on button 0
    b = cyc;
    bus0.btn_raw = 2'b01;
    push(b + 7, 0, 0, K_PRESS);
    push(b + 16, 0, 0, K_RELEASE);
    go_to(b + 9);
    bus0.btn_raw = 2'b00;
    go_to(b + 20);

    // 2: 1-0-1-0 bounce rejected, then stable press
    b = cyc;
    bus0.btn_raw = 2'b01;
    go_to(b + 1); bus0.btn_raw = 2'b00;
    go_to(b + 2); bus0.btn_raw = 2'b01;
    go_to(b + 3); bus0.btn_raw = 2'b00;
    push(b + 16, 0, 0, K_PRESS);
    push(b + 25, 0, 0, K_RELEASE);
    go_to(b + 9);  bus0.btn_raw = 2'b01;
    go_to(b + 18); bus0.btn_raw = 2'b00;
    go_to(b + 30);

    // 3+4: hold with repeats, release bounce restarts hold, clean release
    b = cyc;
    bus0.btn_raw = 2'b01;
    push(b + 7, 0, 0, K_PRESS);
    for (int k = 0; k < 6; k++) push(b + 15 + 3 * k, 0, 0, K_REPEAT);
    push(b + 41, 0, 0, K_REPEAT);
    push(b + 44, 0, 0, K_REPEAT);
    push(b + 47, 0, 0, K_REPEAT);
    push(b + 52, 0, 0, K_RELEASE);
    go_to(b + 28); bus0.btn_raw = 2'b00;
    go_to(b + 30); bus0.btn_raw = 2'b01;
    go_to(b + 45); bus0.btn_raw = 2'b00;
    go_to(b + 56);

    // 5: async reset while repeating, button held through deassertion
    b = cyc;
    bus0.btn_raw = 2'b01;
    push(b + 7, 0, 0, K_PRESS);
    push(b + 15, 0, 0, K_REPEAT);
    push(b + 18, 0, 0, K_REPEAT);
    push(b + 28, 0, 0, K_PRESS);
    push(b + 37, 0, 0, K_RELEASE);
    go_to(b + 19);
    #2 rst = 1'b0;
    go_to(b + 21);
    rst = 1'b1;
    go_to(b + 30); bus0.btn_raw = 2'b00;
    go_to(b + 42);

    // 6: simultaneous presses on both buttons, repeat on vs off
    b = cyc;
    bus0.btn_raw = 2'b11;
    bus1.btn_raw = 2'b11;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) push(b + 7, d, c, K_PRESS);
    for (int k = 0; k < 9; k++)
      for (int c = 0; c < 2; c++) push(b + 15 + 3 * k, 0, c, K_REPEAT);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) push(b + 44, d, c, K_RELEASE);
    go_to(b + 37);
    bus0.btn_raw = 2'b00;
    bus1.btn_raw = 2'b00;
    go_to(b + 50);

    done = 1'b1;
  end

endmodule
